// File: rtl/dic_frame_pkg.sv
// Shared types and constants for the ping-pong frame writer.
package dic_frame_pkg;
  localparam int          WORD_BYTES    = 4;
  localparam int          WIDX_W        = 17;
  localparam logic [31:0] NEW_FRAME_SET = 32'd1;

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, WAIT_DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
  } bram_wr_t;

  // Wrap to 2 rather than 0 so parity is kept and a pair always exists after wrap.
  function automatic logic [31:0] count_next(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? 32'd2 : c + 32'd1;
  endfunction
endpackage

// File: rtl/frame_word_counter.sv
// Word index within the current frame, with terminal-count flag.
module frame_word_counter
  import dic_frame_pkg::*;
#(
  parameter int FRAME_WORDS = 65536
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [WIDX_W-1:0] widx,
  output logic              tc
);
  assign tc = (widx == WIDX_W'(FRAME_WORDS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      widx <= '0;
    else if (clear) widx <= '0;
    else if (inc)   widx <= widx + 1'b1;
  end
endmodule

// File: rtl/frame_writer.sv
// Ping-pong BRAM frame writer: odd frames to BRAM_0, even frames to BRAM_1.
// Optional macro FRAME_WRITER_LEN_CHECK_EN enables s_last length checking.
module frame_writer
  import dic_frame_pkg::*;
#(
  parameter int FRAME_WORDS = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic        proc_done,
  output logic [31:0] bram0_addr,
  output logic [3:0]  bram0_we,
  output logic [31:0] bram0_din,
  output logic [31:0] bram1_addr,
  output logic [3:0]  bram1_we,
  output logic [31:0] bram1_din,
  output logic [31:0] frame_counter,
  output logic [31:0] new_frame,
  output logic        len_err
);
  state_t            state, state_nx;
  logic [WIDX_W-1:0] widx;
  logic              tc;
  logic              accept;
  logic [31:0]       count_nx;
  logic [31:0]       waddr;
  bram_wr_t          wr0, wr1;

  assign s_ready  = (state == WRITE);
  assign accept   = s_ready && s_valid;
  assign count_nx = count_next(frame_counter);
  assign waddr    = 32'(widx) << $clog2(WORD_BYTES);

  frame_word_counter #(.FRAME_WORDS(FRAME_WORDS)) u_cnt (
    .clock (clock),
    .reset (reset),
    .clear (accept && tc),
    .inc   (accept),
    .widx  (widx),
    .tc    (tc)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = WRITE;
      WRITE:     if (accept && tc) state_nx = FLUSH;
      FLUSH:     state_nx = (count_nx == 32'd1) ? WRITE : WAIT_DONE;
      WAIT_DONE: if (proc_done) state_nx = WRITE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Target is parity of the frame being written (frame_counter + 1).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr0 <= '0;
      wr1 <= '0;
    end else begin
      wr0.we <= 4'h0;
      wr1.we <= 4'h0;
      if (accept) begin
        if (!frame_counter[0]) wr0 <= '{addr: waddr, we: 4'hF, din: s_data};
        else                   wr1 <= '{addr: waddr, we: 4'hF, din: s_data};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_counter <= '0;
      new_frame     <= '0;
    end else if (state == FLUSH) begin
      frame_counter <= count_nx;
      if (count_nx != 32'd1) new_frame <= NEW_FRAME_SET;
    end else if (state == WAIT_DONE && proc_done) begin
      new_frame <= '0;
    end
  end

  assign bram0_addr = wr0.addr;
  assign bram0_we   = wr0.we;
  assign bram0_din  = wr0.din;
  assign bram1_addr = wr1.addr;
  assign bram1_we   = wr1.we;
  assign bram1_din  = wr1.din;

`ifdef FRAME_WRITER_LEN_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       len_err <= 1'b0;
    else if (accept && (s_last != tc)) len_err <= 1'b1;
  end
`else
  logic s_last_unused;
  assign s_last_unused = s_last;
  assign len_err       = 1'b0;
`endif
endmodule

// File: doc/frame_writer.md
# frame_writer

Write side of the ping-pong reference/deformed image BRAM pair. The block accepts a 32-bit pixel-word stream and writes each frame into the BRAM whose contents are no longer needed. It maintains `frame_counter` so that frame n lands in BRAM_0 when n is odd and in BRAM_1 when n is even. It then raises `new_frame` for the image-read/DIC pipeline and holds off the next overwrite until that pipeline reports completion.

## Interface
Parameters:
- `FRAME_WORDS`, default 65536: words per frame; legal range 2..131072, so the word index fits in 17 bits.

Ports:
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `s_valid`, in, 1: stream word valid.
- `s_ready`, out, 1: block can accept a word.
- `s_data`, in, 32: pixel word.
- `s_last`, in, 1: marks the final word of a frame; used only when `FRAME_WRITER_LEN_CHECK_EN` is defined.
- `proc_done`, in, 1: one-cycle pulse from the consumer meaning the current pair is finished.
- `bram0_addr`, out, 32: BRAM_0 byte address, equal to word index × 4.
- `bram0_we`, out, 4: BRAM_0 byte write enables.
- `bram0_din`, out, 32: BRAM_0 write data.
- `bram1_addr`, out, 32: BRAM_1 byte address.
- `bram1_we`, out, 4: BRAM_1 byte write enables.
- `bram1_din`, out, 32: BRAM_1 write data.
- `frame_counter`, out, 32: number of completed frames.
- `new_frame`, out, 32: equals 32'd1 while a ref/def pair is ready, otherwise 0.
- `len_err`, out, 1: sticky frame-length mismatch flag.

## Operation
States:
- IDLE: entered on reset. Moves to WRITE unconditionally on the next edge.
- WRITE: `s_ready`=1. Each word is accepted when `s_valid && s_ready`.
- FLUSH: one cycle. The last write is committed and `frame_counter` is updated.
- WAIT_DONE: `s_ready`=0 and `new_frame`=32'd1.

Write path:
- A 17-bit word index `widx` starts at 0 at the start of each frame.
- Each accepted word registers, on the next edge, onto the target BRAM port:
  - addr = {15'b0, widx} << 2
  - din = `s_data`
  - we = 4'hF
- The other BRAM port has we = 0, and its addr/din hold their previous values.
- Target BRAM is selected by the parity of `frame_counter + 1`:
  - odd → BRAM_0
  - even → BRAM_1
- When a word is accepted with `widx == FRAME_WORDS-1`, the state goes to FLUSH and `widx` resets to 0.

Frame completion:
- In FLUSH, all we are 0 and `frame_counter` increments.
- Counter wrap: 0xFFFFFFFF increments to 0x00000002. This preserves parity and keeps the counter ≥2.
- After FLUSH, if the new count is 1, the state returns to WRITE (no pair exists yet).
- If the new count is ≥2, `new_frame` is set to 32'd1 and the state goes to WAIT_DONE.

Handshake with the consumer:
- In WAIT_DONE, `proc_done`=1 clears `new_frame` to 0 and moves the state to WRITE.
- `proc_done` in any other state is ignored.
- Frame n+1 (n≥2) overwrites the BRAM holding frame n−1. This is why writing is blocked until `proc_done`.

Reset:
- Reset at any time, including mid-frame, discards the partial frame.
- Reset values of all outputs are 0: `s_ready`, both addr/we/din sets, `frame_counter`, `new_frame`, `len_err`.
- `widx` also resets to 0.

## Timing
- Write latency: a word accepted at edge N appears on the BRAM port after edge N and is written at edge N+1.
- `new_frame` rises one cycle after the last write is presented, so the BRAM already holds the full frame when the consumer samples it.
- `s_ready` deasserts the cycle after the final word is accepted. It stays low through FLUSH (1 cycle), then through WAIT_DONE if entered.
- After the `proc_done` edge, `s_ready`=1 on the next cycle.
- `s_valid` gaps are allowed. Nothing is written while `s_valid`=0.

## Configuration
`FRAME_WRITER_LEN_CHECK_EN`:
- **Defined:** `s_last` is compared on every accepted word.
  - `s_last`=1 with `widx != FRAME_WORDS-1`, or `s_last`=0 with `widx == FRAME_WORDS-1`, sets `len_err`=1.
  - `len_err` is cleared only by reset.
  - Frame boundaries are still decided by `widx` alone.
- **Undefined:** `s_last` is ignored and `len_err` is tied to 0.

## Structure
- Package `dic_frame_pkg` holds:
  - the state enum (IDLE, WRITE, FLUSH, WAIT_DONE)
  - `WORD_BYTES`=4
  - `WIDX_W`=17
  - `NEW_FRAME_SET`=32'd1
- Sub-module `frame_word_counter` holds the `widx` counter with clear, increment and terminal-count output. Everything else stays in `frame_writer`.

## Test plan
- Reset, then stream frame 1 with `FRAME_WORDS`=4 and data 0xA0..0xA3 → BRAM_0 addr 0,4,8,12 with we=F; `bram1_we` stays 0; `frame_counter`=1; `new_frame`=0; `s_ready` returns to 1.
- Stream frame 2 (0xB0..0xB3) → written to BRAM_1; `frame_counter`=2; `new_frame`=1; `s_ready`=0 until `proc_done`.
- Hold `s_valid` high in WAIT_DONE for 10 cycles, then pulse `proc_done` → no writes occur during the wait; `new_frame`=0; frame 3 goes to BRAM_0 at addr 0.
- Assert reset after 2 words of frame 3 → all outputs 0; the next frame is written to BRAM_0 with `frame_counter` ending at 1.
- Preload `frame_counter`=0xFFFFFFFF via force, then complete a frame → the frame is written to BRAM_1 and the counter reads 2.
- With `FRAME_WRITER_LEN_CHECK_EN` defined, assert `s_last` on word 2 of 4 → `len_err`=1 and stays 1; the frame still ends after word 4.
